// File: rtl/reg_display_scan_if.sv
// Bus bundle for reg_display_scan: capture request/data in, parallel digits and
// multiplexed display drive out.
interface reg_display_scan_if #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
);
  logic [DATA_W-1:0]   data_in;
  logic                load;
  logic                dec_mode;
  logic                blank_lz;
  logic                busy;
  logic                overflow;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   an;
  logic [3:0]          seg_nib;
  logic                seg_blank;

  modport master (
    output data_in, load, dec_mode, blank_lz,
    input  busy, overflow, digits, an, seg_nib, seg_blank
  );

  modport slave (
    input  data_in, load, dec_mode, blank_lz,
    output busy, overflow, digits, an, seg_nib, seg_blank
  );
endinterface

// File: rtl/reg_display_scan.sv
// Load-register display driver: hex or double-dabble BCD capture, leading-zero
// blanking and free-running active-low digit scanning.
//   state | meaning
//   IDLE  | waiting for load; hex captures complete here in one edge
//   CONV  | double-dabble shifting, one data bit per edge
module reg_display_scan #(
  parameter int DATA_W   = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 4
) (
  input logic              ck,
  input logic              rst_n,
  reg_display_scan_if.slave bus
);
  localparam int NW    = 4 * DIGITS;
  localparam int CW    = $clog2(DATA_W + 1);
  localparam int PSC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [NW-1:0]     acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NW-1:0]     digits_q, digits_d;
  logic              overflow_q, overflow_d;
  logic [PSC_W-1:0]  psc_q, psc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        seg_nib_q, seg_nib_d;
  logic              seg_blank_q, seg_blank_d;

  logic [NW-1:0]     hex_val;
  logic              hex_ovf;
  logic [NW-1:0]     acc_adj, acc_shift, all_nines;
  logic              shift_out, last_step;
  logic [DIGITS-1:0] blank;
  logic              zero_run, psc_wrap;

  // Hex capture: bits beyond the displayable nibbles only raise overflow.
  if (DATA_W > NW) begin : g_wide
    assign hex_val = bus.data_in[NW-1:0];
    assign hex_ovf = |bus.data_in[DATA_W-1:NW];
  end else begin : g_narrow
    assign hex_val = NW'(bus.data_in);
    assign hex_ovf = 1'b0;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign last_step = (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.load && bus.dec_mode) state_d = CONV;
      CONV: if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      acc_adj[4*i +: 4]   = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
      all_nines[4*i +: 4] = 4'h9;
    end
    shift_out = acc_adj[NW-1];
    acc_shift = {acc_adj[NW-2:0], sh_q[DATA_W-1]};
  end

  always_comb begin
    sh_d       = sh_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (bus.load && bus.dec_mode) begin
          sh_d  = bus.data_in;
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = CW'(DATA_W);
        end else if (bus.load) begin
          digits_d   = hex_val;
          overflow_d = hex_ovf;
        end
      end
      CONV: begin
        sh_d  = sh_q << 1;
        acc_d = acc_shift;
        ovf_d = ovf_q | shift_out;
        cnt_d = cnt_q - CW'(1);
        if (last_step) begin
          digits_d   = (ovf_q | shift_out) ? all_nines : acc_shift;
          overflow_d = ovf_q | shift_out;
        end
      end
      default: ;
    endcase
  end

  // Blank a digit when it and everything above it are zero; digit 0 always shows.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (digits_q[4*i +: 4] == 4'h0);
      blank[i] = bus.blank_lz && zero_run && (i != 0);
    end
  end

  always_comb begin
    psc_wrap = (psc_q == PSC_W'(SCAN_DIV - 1));
    psc_d    = psc_wrap ? '0 : psc_q + PSC_W'(1);
    idx_d    = idx_q;
    if (psc_wrap) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    an_d        = '1;
    seg_nib_d   = 4'h0;
    seg_blank_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        an_d[i]     = 1'b0;
        seg_nib_d   = digits_q[4*i +: 4];
        seg_blank_d = blank[i];
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sh_q        <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      digits_q    <= '0;
      overflow_q  <= 1'b0;
      psc_q       <= '0;
      idx_q       <= '0;
      an_q        <= {{(DIGITS-1){1'b1}}, 1'b0};
      seg_nib_q   <= 4'h0;
      seg_blank_q <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      overflow_q  <= overflow_d;
      psc_q       <= psc_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_nib_q   <= seg_nib_d;
      seg_blank_q <= seg_blank_d;
    end
  end

  assign bus.busy      = (state_q == CONV);
  assign bus.overflow  = overflow_q;
  assign bus.digits    = digits_q;
  assign bus.an        = an_q;
  assign bus.seg_nib   = seg_nib_q;
  assign bus.seg_blank = seg_blank_q;
endmodule

// File: tb/tb_reg_display_scan.sv
// Scoreboard bench for reg_display_scan: three instances (3, 2 and 1 digits)
// share one stimulus stream; expectations come from arithmetic digit models.
module tb_reg_display_scan;
  logic ck = 1'b0;
  logic rst_n = 1'b1;
  always #5 ck = ~ck;

  reg_display_scan_if #(.DATA_W(8), .DIGITS(3)) bus3();
  reg_display_scan_if #(.DATA_W(8), .DIGITS(2)) bus2();
  reg_display_scan_if #(.DATA_W(8), .DIGITS(1)) bus1();

  reg_display_scan #(.DATA_W(8), .DIGITS(3), .SCAN_DIV(4)) u_d3 (.ck(ck), .rst_n(rst_n), .bus(bus3));
  reg_display_scan #(.DATA_W(8), .DIGITS(2), .SCAN_DIV(1)) u_d2 (.ck(ck), .rst_n(rst_n), .bus(bus2));
  reg_display_scan #(.DATA_W(8), .DIGITS(1), .SCAN_DIV(2)) u_d1 (.ck(ck), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    int          due;
    bit          dec;
    logic [11:0] d3; logic o3;
    logic [11:0] d2; logic o2;
    logic [11:0] d1; logic o1;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ecnt = 0;
  int          busy_end = 0;
  bit          blz = 1'b0;
  logic [11:0] cur3 = '0, cur2 = '0, cur1 = '0;

  always @(posedge ck) cyc <= cyc + 1;
  always @(posedge ck or negedge rst_n)
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Display value as the board would show it: decimal digits or hex nibbles.
  function automatic void model(input int v, input bit dec, input int nd,
                                output logic [11:0] dg, output logic ov);
    int t;
    int base;
    int lim;
    base = dec ? 10 : 16;
    lim  = base ** nd;
    dg = '0;
    ov = (v >= lim);
    t  = v;
    for (int i = 0; i < nd; i++) begin
      if (dec && ov) dg[4*i +: 4] = 4'h9;
      else           dg[4*i +: 4] = 4'(t % base);
      t = t / base;
    end
  endfunction

  function automatic bit blank_model(input logic [11:0] d, input int nd, input int idx, input bit b);
    if (!b || idx == 0) return 1'b0;
    for (int j = idx; j < nd; j++)
      if (d[4*j +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic issue(input logic [7:0] v, input bit ld, input bit dec);
    exp_t e;
    int   e0;
    e0 = cyc + 1;
    if (ld && e0 > busy_end) begin
      e.dec = dec;
      e.due = dec ? e0 + 8 : e0;
      model(int'(v), dec, 3, e.d3, e.o3);
      model(int'(v), dec, 2, e.d2, e.o2);
      model(int'(v), dec, 1, e.d1, e.o1);
      sbq.push_back(e);
      if (dec) busy_end = e0 + 8;
    end
    bus3.data_in = v; bus3.load = ld; bus3.dec_mode = dec; bus3.blank_lz = blz;
    bus2.data_in = v; bus2.load = ld; bus2.dec_mode = dec; bus2.blank_lz = blz;
    bus1.data_in = v; bus1.load = ld; bus1.dec_mode = dec; bus1.blank_lz = blz;
  endtask

  task automatic do_load(input logic [7:0] v, input bit dec);
    @(posedge ck); #1 issue(v, 1'b1, dec);
    @(posedge ck); #1 issue(v, 1'b0, dec);
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() > 0 && t < 60) begin
      @(posedge ck);
      t++;
    end
    chk("drain_pending", sbq.size(), 0);
    repeat (2) @(posedge ck);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_busy"}, bus3.busy, 0);
    chk({nm, "_ovf"}, bus3.overflow, 0);
    chk({nm, "_digits"}, bus3.digits, 0);
    chk({nm, "_an3"}, bus3.an, 3'b110);
    chk({nm, "_nib"}, bus3.seg_nib, 0);
    chk({nm, "_blank"}, bus3.seg_blank, 0);
    chk({nm, "_an2"}, bus2.an, 2'b10);
    chk({nm, "_an1"}, bus1.an, 1'b0);
  endtask

  // Scan slot after edge k: index advanced every SCAN_DIV edges, outputs one edge late.
  task automatic check_scan(input int n);
    int k, i3, i2;
    logic [2:0] e3;
    logic [1:0] e2;
    repeat (n) begin
      @(negedge ck);
      k  = ecnt;
      i3 = (k == 0) ? 0 : ((k - 1) / 4) % 3;
      i2 = (k == 0) ? 0 : (k - 1) % 2;
      e3 = 3'b111; e3[i3] = 1'b0;
      e2 = 2'b11;  e2[i2] = 1'b0;
      chk("scan_an3", bus3.an, e3);
      chk("scan_nib3", bus3.seg_nib, cur3[4*i3 +: 4]);
      chk("scan_blank3", bus3.seg_blank, blank_model(cur3, 3, i3, blz));
      chk("scan_an2", bus2.an, e2);
      chk("scan_nib2", bus2.seg_nib, cur2[4*i2 +: 4]);
      chk("scan_blank2", bus2.seg_blank, blank_model(cur2, 2, i2, blz));
      chk("scan_an1", bus1.an, 1'b0);
      chk("scan_nib1", bus1.seg_nib, cur1[3:0]);
      chk("scan_blank1", bus1.seg_blank, 0);
    end
  endtask

  task automatic set_blz(input bit b);
    @(posedge ck); #1;
    blz = b;
    bus3.blank_lz = b; bus2.blank_lz = b; bus1.blank_lz = b;
    repeat (2) @(posedge ck);
  endtask

  // Monitor: pops expectations when their result is due, checks busy run length.
  int run = 0;
  always @(negedge ck) begin
    if (!rst_n) run = 0;
    else begin
      if (bus3.busy) run++;
      else if (run != 0) begin
        chk("busy_len", run, 8);
        run = 0;
      end
      if (sbq.size() > 0) begin
        if (sbq[0].dec && cyc == sbq[0].due - 1) begin
          chk("hold_d3", bus3.digits, cur3);
          chk("hold_d2", bus2.digits, cur2[7:0]);
          chk("busy_before_end", bus3.busy, 1);
        end
        if (cyc == sbq[0].due) begin
          chk("digits3", bus3.digits, sbq[0].d3);
          chk("ovf3", bus3.overflow, sbq[0].o3);
          chk("digits2", bus2.digits, sbq[0].d2[7:0]);
          chk("ovf2", bus2.overflow, sbq[0].o2);
          chk("digits1", bus1.digits, sbq[0].d1[3:0]);
          chk("ovf1", bus1.overflow, sbq[0].o1);
          chk("busy_at_end", bus3.busy, 0);
          cur3 = sbq[0].d3; cur2 = sbq[0].d2; cur1 = sbq[0].d1;
          void'(sbq.pop_front());
        end else if (cyc > sbq[0].due) begin
          chk("result_missed", cyc, sbq[0].due);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] v;
    bit ld, dec;
    issue(8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge ck);
    #1 check_reset("reset");
    @(posedge ck); #3 rst_n = 1'b1;
    check_scan(6);

    do_load(8'h9F, 1'b0);
    drain();
    chk("hex_9f", bus3.digits, 12'h09F);
    check_scan(24);
    set_blz(1'b1);
    check_scan(24);
    set_blz(1'b0);

    do_load(8'd159, 1'b1);
    drain();
    chk("dec_159", bus3.digits, 12'h159);
    check_scan(24);

    do_load(8'd255, 1'b1);
    @(posedge ck);
    do_load(8'd7, 1'b1);
    drain();
    chk("lockout_255", bus3.digits, 12'h255);
    repeat (10) begin
      @(negedge ck);
      chk("no_extra_busy", bus3.busy, 0);
    end

    do_load(8'd200, 1'b1);
    drain();
    chk("ovf_d2_99", bus2.digits, 8'h99);
    do_load(8'd42, 1'b1);
    drain();
    chk("d2_42", bus2.digits, 8'h42);
    do_load(8'h1F, 1'b0);
    drain();
    chk("d1_hex_1f", bus1.digits, 4'hF);
    chk("d1_ovf", bus1.overflow, 1);

    do_load(8'd123, 1'b1);
    repeat (3) @(posedge ck);
    #2 rst_n = 1'b0;
    sbq.delete();
    busy_end = 0;
    cur3 = '0; cur2 = '0; cur1 = '0;
    #1 check_reset("midconv_reset");
    repeat (3) @(posedge ck);
    #3 rst_n = 1'b1;
    check_scan(8);
    do_load(8'd99, 1'b1);
    drain();
    chk("after_reset_99", bus3.digits, 12'h099);

    repeat (400) begin
      @(posedge ck); #1;
      ld  = ($urandom_range(0, 3) == 0);
      dec = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 5))
        0: v = 8'd0;
        1: v = 8'd99;
        2: v = 8'd100;
        3: v = 8'd255;
        default: v = 8'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0) blz = ~blz;
      issue(v, ld, dec);
    end
    @(posedge ck); #1 issue(8'h00, 1'b0, 1'b0);
    drain();
    check_scan(30);
    set_blz(~blz);
    check_scan(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
